// File: rtl/nios_led_pio_sequencer.sv
// Avalon-MM programmable LED sequencer: the CPU sets enable/mode/period/pattern and
// the block then writes each new LED pattern to the LED PIO data register by itself.
module nios_led_pio_sequencer #(
    parameter int PERIOD_WIDTH   = 26,
    parameter int DEFAULT_PERIOD = 50000000,
    parameter int ONESHOT_STEPS  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ZERO = {PERIOD_WIDTH{1'b0}};
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE  = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_RST  = PERIOD_WIDTH'(DEFAULT_PERIOD);
    localparam logic [7:0]              ONESHOT_CNT = 8'(ONESHOT_STEPS);

    // Returns {next_dir, next_pattern}; dir 0 = moving left, 1 = moving right.
    function automatic logic [8:0] step_pattern(input logic [7:0] p, input logic dir,
                                                input logic bounce);
        logic [7:0] rol;
        logic [7:0] ror;
        rol = {p[6:0], p[7]};
        ror = {p[0], p[7:1]};
        if (!bounce) begin
            step_pattern = {dir, rol};
        end else if (!dir) begin
            step_pattern = p[7] ? {1'b1, ror} : {1'b0, rol};
        end else begin
            step_pattern = p[0] ? {1'b0, rol} : {1'b1, ror};
        end
    endfunction

    state_t                  state_q, state_d;
    logic [2:0]              ctrl_q, ctrl_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [PERIOD_WIDTH-1:0] counter_q, counter_d;
    logic [7:0]              pattern_q, pattern_d;
    logic                    dir_q, dir_d;
    logic [7:0]              step_cnt_q, step_cnt_d;
    logic                    done_q, done_d;
    logic                    pending_q, pending_d;
    logic                    pio_cs_q, pio_cs_d;
    logic                    pio_wn_q, pio_wn_d;
    logic [7:0]              pio_wd_q, pio_wd_d;
    logic                    pio_src_cpu_q, pio_src_cpu_d;

    logic       slv_wr_s, wr_ctrl_s, wr_period_s, wr_pattern_s, wr_status_s;
    logic       cpu_req_s, cpu_issue_s, step_fire_s, running_s;
    logic [8:0] step_s;
    logic       unused_wdata_s;

    assign unused_wdata_s = ^writedata[31:PERIOD_WIDTH];
    assign running_s      = (state_q != ST_IDLE);

    // Slave decode; a CPU pattern write is held off only behind another CPU strobe.
    always_comb begin
        slv_wr_s     = chipselect && !write_n;
        wr_ctrl_s    = slv_wr_s && (address == 2'd0);
        wr_period_s  = slv_wr_s && (address == 2'd1);
        wr_pattern_s = slv_wr_s && (address == 2'd2);
        wr_status_s  = slv_wr_s && (address == 2'd3);
        cpu_req_s    = wr_pattern_s || pending_q;
        cpu_issue_s  = cpu_req_s && !(pio_cs_q && pio_src_cpu_q);
        step_s       = step_pattern(pattern_q, dir_q, ctrl_q[1]);
    end

    // Register writes, sequencing FSM and master strobe generation.
    always_comb begin
        state_d       = state_q;
        ctrl_d        = ctrl_q;
        period_d      = period_q;
        counter_d     = counter_q;
        pattern_d     = pattern_q;
        dir_d         = dir_q;
        step_cnt_d    = step_cnt_q;
        done_d        = done_q;
        pending_d     = cpu_req_s && !cpu_issue_s;
        pio_cs_d      = 1'b0;
        pio_wn_d      = 1'b1;
        pio_wd_d      = pio_wd_q;
        pio_src_cpu_d = 1'b0;
        step_fire_s   = 1'b0;

        if (wr_ctrl_s) begin
            ctrl_d = writedata[2:0];
        end else begin
            ctrl_d = ctrl_q;
        end

        if (wr_period_s) begin
            period_d = (writedata[PERIOD_WIDTH-1:0] == PERIOD_ZERO) ? PERIOD_ONE
                                                                   : writedata[PERIOD_WIDTH-1:0];
        end else begin
            period_d = period_q;
        end

        if (wr_pattern_s) begin
            pattern_d = writedata[7:0];
        end else begin
            pattern_d = pattern_q;
        end

        if (wr_status_s) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_ctrl_s && writedata[0]) begin
                    state_d    = ST_COUNT;
                    counter_d  = period_q - PERIOD_ONE;
                    step_cnt_d = 8'd0;
                    done_d     = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (!ctrl_d[0]) begin
                    state_d = ST_IDLE;
                end else if (counter_q != PERIOD_ZERO) begin
                    counter_d = counter_q - PERIOD_ONE;
                end else if (cpu_req_s && !cpu_issue_s) begin
                    state_d = ST_COUNT;
                end else begin
                    // A CPU pattern landing on the step boundary replaces the step.
                    state_d = ST_WRITE;
                    if (cpu_req_s) begin
                        step_fire_s = 1'b0;
                    end else begin
                        step_fire_s        = 1'b1;
                        {dir_d, pattern_d} = step_s;
                        step_cnt_d         = step_cnt_q + 8'd1;
                    end
                end
            end
            ST_WRITE: begin
                if (ctrl_q[2] && !pio_src_cpu_q && (step_cnt_q == ONESHOT_CNT)) begin
                    ctrl_d[0] = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else if (!ctrl_d[0]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_COUNT;
                    counter_d = period_q - PERIOD_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cpu_issue_s) begin
            pio_cs_d      = 1'b1;
            pio_wn_d      = 1'b0;
            pio_wd_d      = pattern_d;
            pio_src_cpu_d = 1'b1;
        end else if (step_fire_s) begin
            pio_cs_d      = 1'b1;
            pio_wn_d      = 1'b0;
            pio_wd_d      = pattern_d;
            pio_src_cpu_d = 1'b0;
        end else begin
            pio_cs_d      = 1'b0;
            pio_wn_d      = 1'b1;
            pio_wd_d      = pio_wd_q;
            pio_src_cpu_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ctrl_q        <= 3'd0;
            period_q      <= PERIOD_RST;
            counter_q     <= PERIOD_ZERO;
            pattern_q     <= 8'd0;
            dir_q         <= 1'b0;
            step_cnt_q    <= 8'd0;
            done_q        <= 1'b0;
            pending_q     <= 1'b0;
            pio_cs_q      <= 1'b0;
            pio_wn_q      <= 1'b1;
            pio_wd_q      <= 8'd0;
            pio_src_cpu_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            period_q      <= period_d;
            counter_q     <= counter_d;
            pattern_q     <= pattern_d;
            dir_q         <= dir_d;
            step_cnt_q    <= step_cnt_d;
            done_q        <= done_d;
            pending_q     <= pending_d;
            pio_cs_q      <= pio_cs_d;
            pio_wn_q      <= pio_wn_d;
            pio_wd_q      <= pio_wd_d;
            pio_src_cpu_q <= pio_src_cpu_d;
        end
    end

    // Zero-latency slave read mux.
    always_comb begin
        case (address)
            2'd0:    readdata = {29'd0, ctrl_q};
            2'd1:    readdata = {{(32-PERIOD_WIDTH){1'b0}}, period_q};
            2'd2:    readdata = {24'd0, pattern_q};
            2'd3:    readdata = {8'd0, step_cnt_q, pattern_q, 6'd0, done_q, running_s};
            default: readdata = 32'd0;
        endcase
    end

    assign pio_address    = 2'd0;
    assign pio_chipselect = pio_cs_q;
    assign pio_write_n    = pio_wn_q;
    assign pio_writedata  = {24'd0, pio_wd_q};

endmodule

// File: tb/tb_nios_led_pio_sequencer.sv
// Directed self-checking bench for nios_led_pio_sequencer: register map, step
// timing, rotate/bounce/oneshot sequences, boundary collisions and reset.
module tb_nios_led_pio_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;

    int checks = 0;
    int passed = 0;
    logic [7:0] exp_p;
    logic [7:0] bnc_tbl [13] = '{8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h06,
                                 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h60};

    always #5 clk = ~clk;

    nios_led_pio_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a falling edge; the write is captured on the next rising edge.
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic expect_strobe(input logic [7:0] exp, input int exp_n, input string tag);
        int n;
        n = 0;
        while (pio_chipselect !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, " strobe"}, {31'd0, pio_chipselect}, 32'd1);
        check({tag, " wait"}, 32'(n), 32'(exp_n));
        check({tag, " data"}, pio_writedata, {24'd0, exp});
        check({tag, " wr_n"}, {30'd0, pio_address, pio_write_n}, 32'd0);
        @(negedge clk);
        check({tag, " single"}, {31'd0, pio_chipselect}, 32'd0);
    endtask

    task automatic expect_quiet(input int cycles, input string tag);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1) begin
                hits++;
            end
            @(negedge clk);
        end
        check(tag, 32'(hits), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check("rst pio_cs", {31'd0, pio_chipselect}, 32'd0);
        check("rst pio_wn", {31'd0, pio_write_n}, 32'd1);
        check("rst pio_wd", pio_writedata, 32'd0);
        bus_rd(2'd0, 32'd0, "rst ctrl");
        bus_rd(2'd1, 32'd50000000, "rst period");
        bus_rd(2'd2, 32'd0, "rst pattern");
        bus_rd(2'd3, 32'd0, "rst status");

        // Rotate-left, PERIOD=4: strobes every 5 cycles
        bus_wr(2'd1, 32'd4);
        bus_wr(2'd2, 32'h01);
        expect_strobe(8'h01, 0, "rot cpu");
        bus_wr(2'd0, 32'h1);
        exp_p = 8'h01;
        for (int i = 0; i < 8; i++) begin
            exp_p = {exp_p[6:0], exp_p[7]};
            expect_strobe(exp_p, 4, $sformatf("rot step%0d", i + 1));
        end
        bus_rd(2'd3, 32'h0008_0101, "rot status");

        // CPU pattern on the counter==0 cycle replaces the step
        repeat (3) @(negedge clk);
        bus_wr(2'd2, 32'h55);
        expect_strobe(8'h55, 0, "collide cpu");
        expect_strobe(8'hAA, 4, "collide next");

        // Disable two cycles before a step
        @(negedge clk);
        bus_wr(2'd0, 32'h0);
        expect_quiet(12, "disable quiet");
        bus_rd(2'd3, 32'h0009_AA00, "disable status");

        // Bounce, PERIOD=1, from 0xC0
        bus_wr(2'd1, 32'd1);
        bus_wr(2'd2, 32'hC0);
        expect_strobe(8'hC0, 0, "bnc cpu");
        bus_wr(2'd0, 32'h3);
        for (int i = 0; i < 13; i++) begin
            expect_strobe(bnc_tbl[i], 1, $sformatf("bnc step%0d", i + 1));
        end
        // Disable lands on the cycle the next step would be computed
        bus_wr(2'd0, 32'h0);
        expect_quiet(10, "bnc discard quiet");
        bus_rd(2'd3, 32'h000D_6000, "bnc status");

        // Oneshot rotate, PERIOD=2
        bus_wr(2'd1, 32'd2);
        bus_wr(2'd2, 32'h01);
        expect_strobe(8'h01, 0, "one cpu");
        bus_wr(2'd0, 32'h5);
        exp_p = 8'h01;
        for (int i = 0; i < 8; i++) begin
            exp_p = {exp_p[6:0], exp_p[7]};
            expect_strobe(exp_p, 2, $sformatf("one step%0d", i + 1));
        end
        expect_quiet(12, "one quiet");
        bus_rd(2'd3, 32'h0008_0102, "one status done");
        bus_rd(2'd0, 32'h4, "one ctrl");
        bus_wr(2'd3, 32'd0);
        bus_rd(2'd3, 32'h0008_0100, "one status clr");

        // Reset in the middle of COUNT
        bus_wr(2'd1, 32'd4);
        bus_wr(2'd0, 32'h1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("rst2 pio_wd", pio_writedata, 32'd0);
        expect_quiet(12, "rst2 quiet");
        bus_rd(2'd0, 32'd0, "rst2 ctrl");
        bus_rd(2'd1, 32'd50000000, "rst2 period");
        bus_rd(2'd2, 32'd0, "rst2 pattern");
        bus_rd(2'd3, 32'd0, "rst2 status");

        // PERIOD boundary values
        bus_wr(2'd1, 32'd0);
        bus_rd(2'd1, 32'd1, "period zero");
        bus_wr(2'd1, 32'hFFFF_FFFF);
        bus_rd(2'd1, 32'h03FF_FFFF, "period mask");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
